// File: rtl/armleocpu_mul_sequencer.sv
// Sequencer for the shared 32x32->64 unsigned multiplier implementing RV32M MUL/MULH/MULHSU/MULHU.
// Converts signed operands to magnitudes, issues a start pulse, re-applies the sign and returns one half.
module armleocpu_mul_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic        kill,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic        mul_valid,
  output logic [31:0] mul_factor0,
  output logic [31:0] mul_factor1,
  input  logic        mul_ready,
  input  logic [63:0] mul_result
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t           state;
  logic             neg;
  logic             is_lo;
  logic [CNT_W-1:0] counter;

  logic             rs1_signed;
  logic             rs2_signed;
  logic [31:0]      rs1_mag;
  logic [31:0]      rs2_mag;
  logic [63:0]      prod;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout;

  // Operand conditioning; |0x80000000| wraps to itself and is then treated as unsigned.
  assign rs1_signed = (req_op == OP_MULH) || (req_op == OP_MULHSU);
  assign rs2_signed = (req_op == OP_MULH);
  assign rs1_mag    = (rs1_signed && req_rs1[31]) ? (~req_rs1 + 32'd1) : req_rs1;
  assign rs2_mag    = (rs2_signed && req_rs2[31]) ? (~req_rs2 + 32'd1) : req_rs2;

  assign prod    = neg ? (~mul_result + 64'd1) : mul_result;
  assign cnt_inc = counter + CNT_W'(1);
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_data    <= 32'd0;
      rsp_error   <= 1'b0;
      mul_valid   <= 1'b0;
      mul_factor0 <= 32'd0;
      mul_factor1 <= 32'd0;
      neg         <= 1'b0;
      is_lo       <= 1'b0;
      counter     <= '0;
    end else begin
      mul_valid <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && !kill) begin
            mul_factor0 <= rs1_mag;
            mul_factor1 <= rs2_mag;
            neg         <= (rs1_signed & req_rs1[31]) ^ (rs2_signed & req_rs2[31]);
            is_lo       <= (req_op == OP_MUL);
            mul_valid   <= 1'b1;
            req_ready   <= 1'b0;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          counter <= '0;
          if (kill) begin
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          counter <= cnt_inc;
          if (mul_ready && kill) begin
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end else if (mul_ready) begin
            rsp_valid <= 1'b1;
            rsp_data  <= is_lo ? prod[31:0] : prod[63:32];
            state     <= S_RESP;
          end else if (kill) begin
            state <= S_DRAIN;
          end else if (timeout) begin
            rsp_valid <= 1'b1;
            rsp_error <= 1'b1;
            rsp_data  <= 32'd0;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        S_DRAIN: begin
          // Swallow the in-flight multiplier result; watchdog exits silently.
          counter <= cnt_inc;
          if (mul_ready || timeout) begin
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_armleocpu_mul_sequencer.sv
// Directed bench for armleocpu_mul_sequencer with a behavioural multiplier stub.
module tb_armleocpu_mul_sequencer;

  localparam int unsigned T = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        kill;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        mul_valid;
  logic [31:0] mul_factor0;
  logic [31:0] mul_factor1;
  logic        mul_ready;
  logic [63:0] mul_result;

  int n_checks = 0;
  int n_fail   = 0;

  armleocpu_mul_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .kill(kill),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .mul_valid(mul_valid), .mul_factor0(mul_factor0), .mul_factor1(mul_factor1),
    .mul_ready(mul_ready), .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  // Multiplier stub: answers stub_lat cycles after the start pulse unless held.
  int          stub_lat  = 3;
  bit          stub_hold = 1'b0;
  bit          stub_busy;
  int          stub_cnt;
  logic [63:0] stub_prod;

  always @(posedge clk) begin
    mul_ready <= 1'b0;
    if (rst) begin
      stub_busy  <= 1'b0;
      mul_result <= 64'd0;
    end else if (mul_valid) begin
      stub_busy <= 1'b1;
      stub_cnt  <= stub_lat;
      stub_prod <= {32'd0, mul_factor0} * {32'd0, mul_factor1};
    end else if (stub_busy && !stub_hold) begin
      if (stub_cnt == 0) begin
        mul_ready  <= 1'b1;
        mul_result <= stub_prod;
        stub_busy  <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] data, output logic err, output int mv,
                        output logic [31:0] f0, output logic [31:0] f1, output bit got);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b;
    @(negedge clk);
    req_valid = 1'b0;
    got = 1'b0; mv = 0; data = 32'hx; err = 1'bx; f0 = 32'hx; f1 = 32'hx;
    for (int i = 0; i < 200 && !got; i++) begin
      if (mul_valid) begin mv++; f0 = mul_factor0; f1 = mul_factor1; end
      if (rsp_valid) begin got = 1'b1; data = rsp_data; err = rsp_error; end
      else @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_rs1 = 32'd0; req_rs2 = 32'd0; kill = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_checks++; if (rsp_data !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
    n_checks++; if (rsp_error !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_error got %b want 0", rsp_error); end
    n_checks++; if (mul_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mul_valid got %b want 0", mul_valid); end
    n_checks++; if ({mul_factor0, mul_factor1} !== 64'd0) begin n_fail++; $display("FAIL reset_factors got %h want 0", {mul_factor0, mul_factor1}); end
    rst = 1'b0;
  endtask

  task automatic test_mul;
    logic [31:0] d, f0, f1; logic e; int mv; bit got;
    run_op(2'b00, 32'd64, 32'd53, d, e, mv, f0, f1, got);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL mul_rsp_seen got %b want 1", got); end
    n_checks++; if (d !== 32'h00000D40) begin n_fail++; $display("FAIL mul_64x53 got %h want 00000d40", d); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL mul_error got %b want 0", e); end
    n_checks++; if (mv != 1) begin n_fail++; $display("FAIL mul_valid_cycles got %0d want 1", mv); end
  endtask

  task automatic test_mulhu;
    logic [31:0] d, f0, f1; logic e; int mv; bit got;
    run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, d, e, mv, f0, f1, got);
    n_checks++; if (d !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mulhu_max got %h want fffffffe", d); end
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, d, e, mv, f0, f1, got);
    n_checks++; if (d !== 32'h00000001) begin n_fail++; $display("FAIL mul_max_lo got %h want 00000001", d); end
  endtask

  task automatic test_mulh;
    logic [31:0] d, f0, f1; logic e; int mv; bit got;
    run_op(2'b01, 32'h80000000, 32'h80000000, d, e, mv, f0, f1, got);
    n_checks++; if (d !== 32'h40000000) begin n_fail++; $display("FAIL mulh_minint got %h want 40000000", d); end
    n_checks++; if (f0 !== 32'h80000000) begin n_fail++; $display("FAIL mulh_minint_mag got %h want 80000000", f0); end
    run_op(2'b01, 32'hFFFFFFFB, 32'd3, d, e, mv, f0, f1, got);
    n_checks++; if (d !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulh_m5x3 got %h want ffffffff", d); end
    n_checks++; if ({f0, f1} !== {32'd5, 32'd3}) begin n_fail++; $display("FAIL mulh_m5x3_factors got %h want 0000000500000003", {f0, f1}); end
    run_op(2'b00, 32'hFFFFFFFB, 32'd3, d, e, mv, f0, f1, got);
    n_checks++; if (d !== 32'hFFFFFFF1) begin n_fail++; $display("FAIL mul_m5x3 got %h want fffffff1", d); end
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, d, e, mv, f0, f1, got);
    n_checks++; if (d !== 32'h00000000) begin n_fail++; $display("FAIL mulh_m1xm1 got %h want 00000000", d); end
  endtask

  task automatic test_mulhsu;
    logic [31:0] d, f0, f1; logic e; int mv; bit got;
    run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, d, e, mv, f0, f1, got);
    n_checks++; if (d !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulhsu_m1 got %h want ffffffff", d); end
    n_checks++; if (f1 !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulhsu_rs2_unsigned got %h want ffffffff", f1); end
    run_op(2'b10, 32'd0, 32'hDEADBEEF, d, e, mv, f0, f1, got);
    n_checks++; if (d !== 32'h00000000) begin n_fail++; $display("FAIL mulhsu_zero got %h want 00000000", d); end
  endtask

  task automatic test_kill;
    logic [31:0] d, f0, f1; logic e; int mv; bit got;
    bit seen_mr = 1'b0, early = 1'b0, rsp_seen = 1'b0;
    stub_lat = 10;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_rs1 = 32'd1; req_rs2 = 32'd2;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    kill = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      kill = 1'b0;
      if (rsp_valid) rsp_seen = 1'b1;
      if (seen_mr) break;
      if (req_ready) early = 1'b1;
      if (mul_ready) seen_mr = 1'b1;
    end
    n_checks++; if (seen_mr !== 1'b1) begin n_fail++; $display("FAIL kill_mul_ready_seen got %b want 1", seen_mr); end
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL kill_req_ready_early got %b want 0", early); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL kill_req_ready_after got %b want 1", req_ready); end
    repeat (3) begin @(negedge clk); if (rsp_valid) rsp_seen = 1'b1; end
    n_checks++; if (rsp_seen !== 1'b0) begin n_fail++; $display("FAIL kill_no_rsp got %b want 0", rsp_seen); end
    stub_lat = 3;
    run_op(2'b00, 32'd7, 32'd6, d, e, mv, f0, f1, got);
    n_checks++; if (d !== 32'h0000002A) begin n_fail++; $display("FAIL kill_next_7x6 got %h want 0000002a", d); end
  endtask

  task automatic test_reset_mid_wait;
    stub_hold = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_rs1 = 32'd9; req_rs2 = 32'd9;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstwait_req_ready got %b want 1", req_ready); end
    n_checks++; if ({rsp_valid, rsp_error, mul_valid} !== 3'b000) begin n_fail++; $display("FAIL rstwait_flags got %b want 000", {rsp_valid, rsp_error, mul_valid}); end
    n_checks++; if (rsp_data !== 32'd0) begin n_fail++; $display("FAIL rstwait_rsp_data got %h want 0", rsp_data); end
    n_checks++; if ({mul_factor0, mul_factor1} !== 64'd0) begin n_fail++; $display("FAIL rstwait_factors got %h want 0", {mul_factor0, mul_factor1}); end
  endtask

  task automatic test_timeout;
    logic [31:0] d, f0, f1; logic e; int mv; bit got;
    int k = 0;
    bit hit = 1'b0;
    stub_hold = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b11; req_rs1 = 32'd5; req_rs2 = 32'd5;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++; if (mul_valid !== 1'b1) begin n_fail++; $display("FAIL timeout_issue got %b want 1", mul_valid); end
    for (k = 0; k < int'(T) + 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin hit = 1'b1; break; end
    end
    n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL timeout_rsp_seen got %b want 1", hit); end
    n_checks++; if (k != int'(T)) begin n_fail++; $display("FAIL timeout_latency got %0d want %0d", k, T); end
    n_checks++; if (rsp_error !== 1'b1) begin n_fail++; $display("FAIL timeout_error got %b want 1", rsp_error); end
    n_checks++; if (rsp_data !== 32'd0) begin n_fail++; $display("FAIL timeout_data got %h want 0", rsp_data); end
    stub_hold = 1'b0;
    run_op(2'b00, 32'd3, 32'd4, d, e, mv, f0, f1, got);
    n_checks++; if ({e, d} !== {1'b0, 32'd12}) begin n_fail++; $display("FAIL timeout_recover got %h want 00000000c", {e, d}); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulhu();
    test_mulh();
    test_mulhsu();
    test_kill();
    test_reset_mid_wait();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
